// File: rtl/hc283_nibble_sequencer.sv
// hc283_nibble_sequencer
// Multi-cycle wide adder controller. It time-shares one external 4-bit
// adder slice (74HC283 style: a, b, cin -> sum, cout). Operands come in
// through a start valid/ready handshake. The slice is fed one nibble per
// cycle, least-significant first, and the ripple carry is kept in a register
// between cycles. The W-bit result leaves through a done valid/ready
// handshake.
//
// Optional build macro HC283_SEQ_SUB_EN adds the op_sub input. When op_sub
// is set at accept, operand B is inverted and the carry-in is forced to 1,
// so the block computes A - B. res_cout = 1 then means no borrow (A >= B).
//
// NIBBLES must be in 1..16, and IDXW must satisfy 2**IDXW >= NIBBLES.
module hc283_nibble_sequencer #(
  parameter int NIBBLES = 4,
  parameter int IDXW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
`ifdef HC283_SEQ_SUB_EN
  input  logic                 op_sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 res_cout
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_reg;
  logic [W-1:0]    result_reg;
  logic            res_cout_reg;

  logic            start_acc;
  logic            last_nib;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    result_nxt;
  logic [W-1:0]    b_load;
  logic            cin_load;

  assign start_acc = start_valid && (state == IDLE);
  assign last_nib  = (idx == IDXW'(NIBBLES - 1));

  // Operand conditioning at accept: subtraction is A + ~B + 1.
`ifdef HC283_SEQ_SUB_EN
  assign b_load   = op_sub ? ~op_b : op_b;
  assign cin_load = op_sub ? 1'b1  : op_cin;
`else
  assign b_load   = op_b;
  assign cin_load = op_cin;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, step through nibbles, hold in DONE
  // until the host takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid)    state_nxt = RUN;
      RUN:  if (last_nib)       state_nxt = DONE;
      DONE: if (done_ready)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Select the current nibble. The slice inputs are held at zero outside RUN
  // so the shared adder stays quiet.
  always_comb begin
    a_sh    = a_reg >> {idx, 2'b00};
    b_sh    = b_reg >> {idx, 2'b00};
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = carry_reg;
    end
  end

  // Merge the slice sum into the nibble of the result addressed by idx.
  // Other nibbles keep their old value, so the result is not cleared on
  // accept and becomes complete only on entry to DONE.
  always_comb begin
    result_nxt = result_reg;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDXW'(n)) begin
        result_nxt[4*n +: 4] = add_sum;
      end
    end
  end

  // Datapath registers: operand capture at accept, then nibble write-back and
  // carry ripple once per RUN cycle. The final carry-out is captured as the
  // block leaves RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      result_reg   <= '0;
      res_cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_acc) begin
            a_reg     <= op_a;
            b_reg     <= b_load;
            carry_reg <= cin_load;
            idx       <= '0;
          end
        end
        RUN: begin
          result_reg <= result_nxt;
          carry_reg  <= add_cout;
          idx        <= idx + IDXW'(1);
          if (last_nib) begin
            res_cout_reg <= add_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state == RUN) || (state == DONE);
  assign done_valid  = (state == DONE);
  assign result      = result_reg;
  assign res_cout    = res_cout_reg;

endmodule

// File: doc/hc283_nibble_sequencer.md
Name: hc283_nibble_sequencer

Overview:
- Multi-cycle controller that performs a wide add using one shared external 4-bit adder slice (sum[3:0], cout, a, b, cin interface).
- Operands are accepted through a valid/ready start handshake.
- The block feeds the slice one nibble per cycle, least-significant first, and registers the ripple carry between cycles.
- The full-width result is returned through a valid/ready done handshake.
- Sits between a requesting host FSM and the combinational 4-bit adder instance.

Parameters:
- NIBBLES, 4, operand width in nibbles; operand width W = 4*NIBBLES; legal range 1..16.
- IDXW, 4, width of the nibble index counter; must satisfy 2**IDXW >= NIBBLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  host presents an operand set.
- start_ready  output  1  block can accept operands; high only in IDLE.
- op_a  input  W  operand A, sampled at start accept.
- op_b  input  W  operand B, sampled at start accept.
- op_cin  input  1  carry-in, sampled at start accept.
- add_a  output  4  nibble of A to the adder slice.
- add_b  output  4  nibble of B to the adder slice.
- add_cin  output  1  carry to the adder slice.
- add_sum  input  4  slice sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  slice carry-out, combinational.
- busy  output  1  high in RUN or DONE.
- done_valid  output  1  result and res_cout are valid.
- done_ready  input  1  host accepts the result.
- result  output  W  full-width sum.
- res_cout  output  1  final carry-out.

Behaviour:
- Reset is asynchronous and active-high on rst. All state is clocked on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - Index counter, operand registers, result and carry registers = 0.
  - start_ready = 1 (decoded from IDLE), busy = 0, done_valid = 0.
  - result = 0, res_cout = 0, add_a/add_b/add_cin = 0.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: latch op_a, op_b; carry_reg <= op_cin; idx <= 0; go to RUN.
  - start_valid without ready is ignored. The host holds it; it is not queued.
- RUN, one nibble per cycle:
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[same slice], add_cin = carry_reg.
  - At the edge: result[4*idx+3:4*idx] <= add_sum; carry_reg <= add_cout; idx <= idx+1.
  - When idx == NIBBLES-1, go to DONE and load res_cout <= add_cout.
- DONE:
  - done_valid = 1; result and res_cout are held stable.
  - On done_ready: go to IDLE. start_ready rises the following cycle; there is no same-cycle turnaround.
  - With done_ready low, the block stays in DONE indefinitely (backpressure).
- Latency: accept edge to done_valid high = NIBBLES cycles. Throughput = one operation per NIBBLES+2 cycles minimum.
- add_a/add_b/add_cin are driven to 0 outside RUN, so the shared slice is quiescent.
- The result register is not cleared on accept. Nibbles are overwritten in order, and result is valid only while done_valid = 1.
- Arithmetic: unsigned, modulo 2**W. res_cout is bit W of a + b + cin.
- NIBBLES = 1: exactly one RUN cycle, with idx fixed at 0.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and no done_valid pulse occurs.
- done_ready high outside DONE has no effect.

Optional Feature:
- Macro: HC283_SEQ_SUB_EN.
- When defined:
  - Adds input port op_sub (1 bit), sampled at start accept.
  - If op_sub = 1: b_reg <= ~op_b and carry_reg <= 1 (op_cin ignored), giving A - B.
  - res_cout = 1 means no borrow (A >= B).
  - If op_sub = 0: behaviour is identical to the base add.
- When undefined: op_sub does not exist; add-only behaviour as above.

Test Plan:
- NIBBLES=4, op_a=0x1234, op_b=0x4321, op_cin=0, done_ready=1 -> done_valid high 4 cycles after accept; result=0x5555, res_cout=0; add_cin sequence 0,0,0,0.
- op_a=0xFFFF, op_b=0x0001, op_cin=0 -> result=0x0000, res_cout=1; add_cin sequence 0,1,1,1 (full carry ripple).
- op_a=0x0000, op_b=0xFFFF, op_cin=1 -> result=0x0000, res_cout=1; start_ready=0 throughout RUN and DONE.
- Backpressure: 0x00FF+0x0001, done_ready held low 10 cycles -> done_valid, result=0x0100 and res_cout=0 all stable; a new start_valid is not accepted until one cycle after done_ready goes high.
- Reset mid-RUN: assert rst at RUN cycle 2 of 0x1234+0x1111 -> all outputs immediately at reset values; the next operation 0x0001+0x0001 returns 0x0002, res_cout=0.
- With HC283_SEQ_SUB_EN: op_sub=1, 0x0005-0x0007 -> result=0xFFFE, res_cout=0; 0x0007-0x0005 -> result=0x0002, res_cout=1.
